// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch capture, writeback port, forwarding inputs and decoded outputs.
interface decode_stage_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned AW = 5;

  logic             stallD;
  logic             flushD;
  logic [WIDTH-1:0] instrF;
  logic [WIDTH-1:0] pcplus4F;
  logic             regwriteW;
  logic [AW-1:0]    writeregW;
  logic [WIDTH-1:0] resultW;
  logic             forwardAD;
  logic             forwardBD;
  logic [WIDTH-1:0] aluoutM;

  logic [WIDTH-1:0] instrD;
  logic [WIDTH-1:0] pcplus4D;
  logic [WIDTH-1:0] rd1D;
  logic [WIDTH-1:0] rd2D;
  logic [WIDTH-1:0] signimmD;
  logic [AW-1:0]    rsD;
  logic [AW-1:0]    rtD;
  logic [AW-1:0]    rdD;
  logic             branchD;
  logic             equalD;
  logic             pcsrcD;
  logic [WIDTH-1:0] pcbranchD;

  modport master (
    output stallD, flushD, instrF, pcplus4F, regwriteW, writeregW, resultW,
           forwardAD, forwardBD, aluoutM,
    input  instrD, pcplus4D, rd1D, rd2D, signimmD, rsD, rtD, rdD,
           branchD, equalD, pcsrcD, pcbranchD
  );

  modport slave (
    input  stallD, flushD, instrF, pcplus4F, regwriteW, writeregW, resultW,
           forwardAD, forwardBD, aluoutM,
    output instrD, pcplus4D, rd1D, rd2D, signimmD, rsD, rtD, rdD,
           branchD, equalD, pcsrcD, pcbranchD
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: IF/ID register, 32x32 register file with write bypass,
// immediate extension and early beq/bne resolution with M-stage forwarding.
module decode_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32
) (
  input logic          clk,
  input logic          reset,
  decode_stage_if.slave bus
);
  localparam int unsigned AW = 5;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pcplus4_q;
  logic [WIDTH-1:0] regs [NREGS];

  logic [AW-1:0]    rs;
  logic [AW-1:0]    rt;
  logic [5:0]       opcode;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] signimm;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             equal;
  logic             wr_en;

  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign opcode = instr_q[31:26];
  assign wr_en  = bus.regwriteW && (bus.writeregW != '0);

  // IF/ID register: stall holds, flush inserts a nop bubble, otherwise capture fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q   <= '0;
      pcplus4_q <= '0;
    end else if (bus.stallD) begin
      instr_q   <= instr_q;
      pcplus4_q <= pcplus4_q;
    end else if (bus.flushD) begin
      instr_q   <= '0;
      pcplus4_q <= '0;
    end else begin
      instr_q   <= bus.instrF;
      pcplus4_q <= bus.pcplus4F;
    end
  end

  // Register file write port; $0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.writeregW] <= bus.resultW;
    end
  end

  // Combinational reads with same-cycle writeback bypass, then branch compare.
  always_comb begin
    rd1     = '0;
    rd2     = '0;
    if (rs != '0) rd1 = (wr_en && bus.writeregW == rs) ? bus.resultW : regs[rs];
    if (rt != '0) rd2 = (wr_en && bus.writeregW == rt) ? bus.resultW : regs[rt];
    signimm = {{(WIDTH-16){instr_q[15]}}, instr_q[15:0]};
    op_a    = bus.forwardAD ? bus.aluoutM : rd1;
    op_b    = bus.forwardBD ? bus.aluoutM : rd2;
    equal   = (op_a == op_b);
  end

  assign bus.instrD    = instr_q;
  assign bus.pcplus4D  = pcplus4_q;
  assign bus.rd1D      = rd1;
  assign bus.rd2D      = rd2;
  assign bus.signimmD  = signimm;
  assign bus.rsD       = rs;
  assign bus.rtD       = rt;
  assign bus.rdD       = instr_q[15:11];
  assign bus.branchD   = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign bus.equalD    = equal;
  assign bus.pcsrcD    = ((opcode == OP_BEQ) && equal) || ((opcode == OP_BNE) && !equal);
  assign bus.pcbranchD = pcplus4_q + WIDTH'(signimm << 2);
endmodule
